// File: rtl/chirp_symbol_gen_if.sv
// Control/status bundle between the chirp config front end and the chirp core.
// Handshake: a one-cycle i_start is taken only while o_busy is low; o_busy stays
// high for the whole burst, o_done pulses with the last o_valid, and i_abort
// ends a burst at once with no further o_valid or o_done.
interface chirp_symbol_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SF_WIDTH   = 4,
    parameter int MAX_SF     = 12,
    parameter int DIV_WIDTH  = 7,
    parameter int NSYM_WIDTH = 8
);
    logic                  i_start;
    logic                  i_abort;
    logic [SF_WIDTH-1:0]   i_sf;
    logic [MAX_SF-1:0]     i_symbol;
    logic                  i_mode;
    logic [NSYM_WIDTH-1:0] i_nsym;
    logic [DIV_WIDTH-1:0]  i_div;
    logic [DATA_WIDTH-1:0] o_phase;
    logic                  o_valid;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;
    logic                  dbg_run;

    modport master (
        output i_start, i_abort, i_sf, i_symbol, i_mode, i_nsym, i_div,
        input  o_phase, o_valid, o_busy, o_done, o_err, dbg_run
    );

    modport slave (
        input  i_start, i_abort, i_sf, i_symbol, i_mode, i_nsym, i_div,
        output o_phase, o_valid, o_busy, o_done, o_err, dbg_run
    );
endinterface

// File: rtl/chirp_symbol_gen.sv
// LoRa-style up/down chirp phase generator with runtime SF, cyclic symbol
// offset, multi-symbol bursts and programmable sample pacing.
module chirp_symbol_gen #(
    parameter int PHASE_WIDTH = 24,
    parameter int DATA_WIDTH  = 8,
    parameter int SF_WIDTH    = 4,
    parameter int MIN_SF      = 6,
    parameter int MAX_SF      = 12,
    parameter int DIV_WIDTH   = 7,
    parameter int NSYM_WIDTH  = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    chirp_symbol_gen_if.slave bus
);
    localparam int SHW = $clog2(PHASE_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [MAX_SF-1:0]      n_q, n_d;
    logic [NSYM_WIDTH-1:0]  sym_cnt_q, sym_cnt_d;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [SF_WIDTH-1:0]    sf_q, sf_d;
    logic [MAX_SF-1:0]      symbol_q, symbol_d;
    logic                   mode_q, mode_d;
    logic [NSYM_WIDTH-1:0]  nsym_q, nsym_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DATA_WIDTH-1:0]  phase_q, phase_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic [MAX_SF-1:0]      mask;
    logic [MAX_SF-1:0]      k_up;
    logic [MAX_SF-1:0]      k;
    logic [SHW-1:0]         shamt;
    logic [PHASE_WIDTH-1:0] inc;
    logic                   sf_ok;
    logic                   tick;
    logic                   last_sample;
    logic                   last_symbol;

    // mask = N-1; the frequency index wraps modulo N, the downchirp mirrors it
    assign mask        = ~({MAX_SF{1'b1}} << sf_q);
    assign k_up        = (symbol_q + n_q) & mask;
    assign k           = mode_q ? (mask - k_up) : k_up;
    assign shamt       = SHW'(PHASE_WIDTH) - SHW'(sf_q);
    assign inc         = {{(PHASE_WIDTH-MAX_SF){1'b0}}, k} << shamt;
    assign sf_ok       = (bus.i_sf >= SF_WIDTH'(MIN_SF)) && (bus.i_sf <= SF_WIDTH'(MAX_SF));
    assign tick        = (div_cnt_q == div_q);
    assign last_sample = (n_q == mask);
    assign last_symbol = (sym_cnt_q == nsym_q);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        n_d       = n_q;
        sym_cnt_d = sym_cnt_q;
        div_cnt_d = div_cnt_q;
        sf_d      = sf_q;
        symbol_d  = symbol_q;
        mode_d    = mode_q;
        nsym_d    = nsym_q;
        div_d     = div_q;
        phase_d   = phase_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.i_abort && bus.i_start) begin
                    if (sf_ok) begin
                        sf_d      = bus.i_sf;
                        symbol_d  = bus.i_symbol;
                        mode_d    = bus.i_mode;
                        nsym_d    = bus.i_nsym;
                        div_d     = bus.i_div;
                        acc_d     = '0;
                        n_d       = '0;
                        sym_cnt_d = '0;
                        div_cnt_d = '0;
                        busy_d    = 1'b1;
                        state_d   = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (tick) begin
                        div_cnt_d = '0;
                        valid_d   = 1'b1;
                        phase_d   = acc_q[PHASE_WIDTH-1 -: DATA_WIDTH];
                        acc_d     = acc_q + inc;
                        if (last_sample) begin
                            n_d = '0;
                            if (last_symbol) begin
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end else begin
                                sym_cnt_d = sym_cnt_q + 1'b1;
                            end
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            n_q       <= '0;
            sym_cnt_q <= '0;
            div_cnt_q <= '0;
            sf_q      <= '0;
            symbol_q  <= '0;
            mode_q    <= 1'b0;
            nsym_q    <= '0;
            div_q     <= '0;
            phase_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            sym_cnt_q <= sym_cnt_d;
            div_cnt_q <= div_cnt_d;
            sf_q      <= sf_d;
            symbol_q  <= symbol_d;
            mode_q    <= mode_d;
            nsym_q    <= nsym_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_phase = phase_q;
    assign bus.o_valid = valid_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;
    assign bus.o_busy  = busy_q;
    assign bus.dbg_run = (state_q == RUN);
endmodule

// File: tb/tb_chirp_symbol_gen.sv
// Directed bench for chirp_symbol_gen: bursts, offsets, pacing, illegal SF,
// abort and asynchronous reset.
module tb_chirp_symbol_gen;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    chirp_symbol_gen_if #(
        .DATA_WIDTH(8), .SF_WIDTH(4), .MAX_SF(12), .DIV_WIDTH(7), .NSYM_WIDTH(8)
    ) bus ();

    chirp_symbol_gen #(
        .PHASE_WIDTH(24), .DATA_WIDTH(8), .SF_WIDTH(4), .MIN_SF(6),
        .MAX_SF(12), .DIV_WIDTH(7), .NSYM_WIDTH(8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start(input int sf, input int sym, input int mode, input int nsym, input int div);
        bus.i_sf     = sf[3:0];
        bus.i_symbol = sym[11:0];
        bus.i_mode   = mode[0];
        bus.i_nsym   = nsym[7:0];
        bus.i_div    = div[6:0];
        bus.i_start  = 1'b1;
        @(posedge clk); #1;
        bus.i_start  = 1'b0;
    endtask

    task automatic run_burst(input int sf, input int sym, input int mode, input int nsym,
                             input int div, input logic [7:0] hand [5], input bit poke_start,
                             input string name);
        int          total;
        int          nn;
        int          cnt;
        int          budget;
        int          kk;
        int unsigned acc_m;
        logic [7:0]  exp_ph;
        bit          finished;
        nn       = 1 << sf;
        total    = (nsym + 1) * nn;
        cnt      = 0;
        acc_m    = 0;
        finished = 1'b0;
        do_start(sf, sym, mode, nsym, div);
        n_cmp++;
        if (bus.o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, bus.o_busy);
        end
        budget = total * (div + 1) + 16;
        for (int e = 1; e <= budget && !finished; e++) begin
            @(posedge clk); #1;
            if (poke_start) begin
                if (e == 40) begin
                    bus.i_start = 1'b1;
                    bus.i_sf    = 4'd6;
                    bus.i_mode  = ~bus.i_mode;
                    bus.i_div   = 7'd0;
                end else if (e == 41) begin
                    bus.i_start = 1'b0;
                end
            end
            if (bus.o_valid === 1'b1) begin
                n_cmp++;
                if (e != (cnt + 1) * (div + 1)) begin
                    n_err++;
                    $display("FAIL %s valid_timing[%0d]: got edge %0d want edge %0d", name, cnt, e, (cnt + 1) * (div + 1));
                end
                exp_ph = acc_m[23:16];
                n_cmp++;
                if (bus.o_phase !== exp_ph) begin
                    n_err++;
                    $display("FAIL %s phase[%0d]: got %0d want %0d", name, cnt, bus.o_phase, exp_ph);
                end
                if (cnt < 5) begin
                    n_cmp++;
                    if (bus.o_phase !== hand[cnt]) begin
                        n_err++;
                        $display("FAIL %s hand_phase[%0d]: got %0d want %0d", name, cnt, bus.o_phase, hand[cnt]);
                    end
                end
                n_cmp++;
                if (bus.o_done !== (cnt == total - 1)) begin
                    n_err++;
                    $display("FAIL %s done[%0d]: got %b want %b", name, cnt, bus.o_done, (cnt == total - 1));
                end
                kk = (sym + cnt) % nn;
                if (mode != 0) kk = nn - 1 - kk;
                acc_m = (acc_m + (kk << (24 - sf))) & 32'h00FF_FFFF;
                cnt++;
                if (cnt == total) finished = 1'b1;
            end else if (bus.o_done !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s done_without_valid: got %b want 0", name, bus.o_done);
            end
        end
        n_cmp++;
        if (cnt != total) begin
            n_err++;
            $display("FAIL %s sample_count: got %0d want %0d", name, cnt, total);
        end
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_at_done: got %b want 0", name, bus.o_busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.o_valid, bus.o_done, bus.o_busy, bus.dbg_run} !== 4'b0000) begin
            n_err++;
            $display("FAIL %s after_burst v/d/b/run: got %b want 0000", name,
                     {bus.o_valid, bus.o_done, bus.o_busy, bus.dbg_run});
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_abort  = 1'b0;
        bus.i_sf     = '0;
        bus.i_symbol = '0;
        bus.i_mode   = 1'b0;
        bus.i_nsym   = '0;
        bus.i_div    = '0;
        #12;
        n_cmp++;
        if (bus.o_phase !== 8'd0) begin
            n_err++;
            $display("FAIL reset_phase: got %0d want 0", bus.o_phase);
        end
        n_cmp++;
        if ({bus.o_valid, bus.o_busy, bus.o_done, bus.o_err, bus.dbg_run} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_flags v/b/d/e/run: got %b want 00000",
                     {bus.o_valid, bus.o_busy, bus.o_done, bus.o_err, bus.dbg_run});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.o_valid, bus.o_busy, bus.dbg_run} !== 3'b000) begin
            n_err++;
            $display("FAIL post_reset_idle v/b/run: got %b want 000", {bus.o_valid, bus.o_busy, bus.dbg_run});
        end
    endtask

    task automatic test_upchirp();
        run_burst(6, 0, 0, 0, 0, '{8'd0, 8'd0, 8'd4, 8'd12, 8'd24}, 1'b0, "up_sf6");
    endtask

    task automatic test_offset();
        run_burst(6, 62, 0, 0, 0, '{8'd0, 8'd248, 8'd244, 8'd244, 8'd248}, 1'b0, "up_sf6_s62");
    endtask

    task automatic test_downchirp();
        run_burst(6, 0, 1, 0, 0, '{8'd0, 8'd252, 8'd244, 8'd232, 8'd216}, 1'b0, "down_sf6");
    endtask

    task automatic test_burst_paced();
        run_burst(7, 0, 0, 2, 3, '{8'd0, 8'd0, 8'd2, 8'd6, 8'd12}, 1'b1, "burst_sf7_div3");
    endtask

    task automatic test_illegal_sf();
        int bad [2];
        bad = '{5, 13};
        foreach (bad[i]) begin
            bus.i_sf    = bad[i][3:0];
            bus.i_start = 1'b1;
            @(posedge clk); #1;
            bus.i_start = 1'b0;
            n_cmp++;
            if ({bus.o_err, bus.o_busy, bus.o_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL illegal_sf%0d e/b/v: got %b want 100", bad[i], {bus.o_err, bus.o_busy, bus.o_valid});
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.o_err, bus.o_busy, bus.o_valid} !== 3'b000) begin
                n_err++;
                $display("FAIL illegal_sf%0d_next e/b/v: got %b want 000", bad[i], {bus.o_err, bus.o_busy, bus.o_valid});
            end
        end
    endtask

    task automatic test_abort();
        int  cnt;
        bit  seen;
        logic [7:0] hand [5];
        // abort after ten samples
        do_start(6, 0, 0, 0, 0);
        cnt = 0;
        for (int e = 0; e < 40 && cnt < 10; e++) begin
            @(posedge clk); #1;
            if (bus.o_valid === 1'b1) cnt++;
        end
        n_cmp++;
        if (cnt != 10) begin
            n_err++;
            $display("FAIL abort_pre_count: got %0d want 10", cnt);
        end
        bus.i_abort = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        n_cmp++;
        if ({bus.o_valid, bus.o_busy, bus.o_done, bus.dbg_run} !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_mid v/b/d/run: got %b want 0000", {bus.o_valid, bus.o_busy, bus.o_done, bus.dbg_run});
        end
        seen = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL abort_quiet: got activity want none");
        end
        // abort coinciding with the final tick
        do_start(6, 0, 0, 0, 0);
        cnt = 0;
        for (int e = 0; e < 80 && cnt < 63; e++) begin
            @(posedge clk); #1;
            if (bus.o_valid === 1'b1) cnt++;
        end
        bus.i_abort = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        n_cmp++;
        if ({bus.o_valid, bus.o_busy, bus.o_done} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_last v/b/d: got %b want 000 (pre-count %0d)", {bus.o_valid, bus.o_busy, bus.o_done}, cnt);
        end
        // abort in IDLE wins over start
        bus.i_sf    = 4'd6;
        bus.i_abort = 1'b1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        bus.i_start = 1'b0;
        n_cmp++;
        if ({bus.o_busy, bus.o_err, bus.dbg_run} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_idle_prio b/e/run: got %b want 000", {bus.o_busy, bus.o_err, bus.dbg_run});
        end
        hand = '{8'd0, 8'd0, 8'd4, 8'd12, 8'd24};
        run_burst(6, 0, 0, 0, 0, hand, 1'b0, "restart_after_abort");
    endtask

    task automatic test_async_reset();
        do_start(6, 5, 0, 3, 1);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_phase !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset_phase: got %0d want 0", bus.o_phase);
        end
        n_cmp++;
        if ({bus.o_valid, bus.o_busy, bus.o_done, bus.o_err, bus.dbg_run} !== 5'b00000) begin
            n_err++;
            $display("FAIL async_reset_flags v/b/d/e/run: got %b want 00000",
                     {bus.o_valid, bus.o_busy, bus.o_done, bus.o_err, bus.dbg_run});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.o_valid, bus.o_busy, bus.o_done} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset_after v/b/d: got %b want 000", {bus.o_valid, bus.o_busy, bus.o_done});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_upchirp();
        test_offset();
        test_downchirp();
        test_burst_paced();
        test_illegal_sf();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/chirp_symbol_gen.md
Name: chirp_symbol_gen

Overview:
- Parametrised successor chirp core: generates LoRa-style up/down chirp phase samples.
- Supports runtime spreading factor, cyclic symbol offset, multi-symbol bursts and programmable sample pacing.
- Emits truncated phase words with valid strobe; downstream sine LUT/DAC stage converts them.
- Start/busy/done/abort handshake, driven by the UART config front end in the chirp top.

Parameters:
PHASE_WIDTH, 24, phase accumulator width; must be >= MAX_SF + DATA_WIDTH
DATA_WIDTH, 8, output phase width (top bits of accumulator)
SF_WIDTH, 4, width of spreading-factor input
MIN_SF, 6, smallest legal SF
MAX_SF, 12, largest legal SF
DIV_WIDTH, 7, sample-pacing divider width
NSYM_WIDTH, 8, burst length field width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start pulse; accepted only in IDLE
i_abort  in  1  stop burst, return to IDLE
i_sf  in  SF_WIDTH  spreading factor; N = 2^SF samples/symbol
i_symbol  in  MAX_SF  cyclic start frequency index s (low SF bits used)
i_mode  in  1  0 = upchirp, 1 = downchirp
i_nsym  in  NSYM_WIDTH  symbols in burst minus one
i_div  in  DIV_WIDTH  one sample every i_div+1 clocks
o_phase  out  DATA_WIDTH  phase sample = acc[PHASE_WIDTH-1 -: DATA_WIDTH]
o_valid  out  1  one-cycle strobe, o_phase valid
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse with final sample of burst
o_err  out  1  one-cycle pulse: start rejected, illegal SF

Behaviour:
- Reset: state IDLE; acc, counters, o_phase, o_valid, o_busy, o_done, o_err all 0.
- States: IDLE, RUN. All outputs registered.
- IDLE + i_start, MIN_SF<=i_sf<=MAX_SF: latch sf, symbol, mode, nsym, div; acc=0, n=0, sym_cnt=0, div_cnt=0; RUN next cycle, o_busy=1.
- IDLE + i_start, illegal SF: o_err=1 next cycle, stay IDLE.
- i_start in RUN: ignored. Inputs other than i_abort are don't-care in RUN.
- Sample tick: div_cnt counts 0..div, then wraps to 0. Tick when div_cnt==div. First o_valid is div+1 cycles after the accept cycle; o_valid is then periodic every div+1 cycles.
- On tick:
  - o_phase = top DATA_WIDTH bits of acc before the update; o_valid=1.
  - k = (s + n) mod N for upchirp; k = N-1-((s+n) mod N) for downchirp.
  - acc += k << (PHASE_WIDTH - sf), modulo 2^PHASE_WIDTH.
  - n++.
- Symbol wrap: when n reaches N, n=0 and sym_cnt++. acc is not reset, so phase is continuous across symbols. The same s and mode apply to every symbol in the burst.
- Last tick: n==N-1 and sym_cnt==nsym. That tick asserts o_done with o_valid; the next cycle is IDLE with o_busy=0.
- Total samples per burst = (nsym+1)*2^sf.
- i_abort in RUN: IDLE next cycle; no o_valid and no o_done from that cycle on. Abort on the same cycle as the last tick still suppresses that sample and o_done.
- i_abort in IDLE: has priority over a simultaneous i_start; start is ignored.
- Async reset mid-burst: immediate return to reset values; no o_done.
- New burst can start the cycle after IDLE is re-entered.

Test Plan:
- SF=6, s=0, up, nsym=0, div=0, start -> 64 consecutive valids starting the cycle after accept; o_phase 0,0,4,12,24,...; o_done with the 64th; o_busy low the next cycle.
- SF=6, s=62, up -> first samples 0,248,244,244,248 (k=62,63,0,1).
- SF=6, s=0, down -> first samples 0,252,244 (k=63,62,...); o_done after 64 samples.
- SF=7, nsym=2, div=3 -> 384 valids exactly 4 clocks apart; phase continuous across symbol boundaries; single o_done; i_start during the burst ignored.
- i_sf=5 or 13 with start -> o_err one-cycle pulse; o_busy stays 0; no o_valid.
- Abort after 10 samples -> o_valid/o_busy low next cycle, no o_done; new start succeeds. Async reset mid-burst -> all outputs 0 immediately.
